// File: rtl/n_bin_serializer.sv
// Captures a frame of BINS averaged bin words and streams them out one per handshake.
// Optional N_BIN_SER_HEADER_EN prefixes each frame with a frame-counter header word.
module n_bin_serializer #(
  parameter int N    = 16,
  parameter int BINS = 4
) (
  input  logic                        clk,
  input  logic                        arest_n,
  input  logic                        in_valid,
  input  logic [BINS-1:0][N-1:0]      in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N-1:0]                out_data,
  output logic [$clog2(BINS)-1:0]     out_bin_idx,
  output logic                        out_last,
  output logic                        out_hdr,
  output logic [15:0]                 overrun_cnt
);

  localparam int IW = $clog2(BINS);
  localparam logic [IW-1:0] KLAST = IW'(BINS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd2;
`ifdef N_BIN_SER_HEADER_EN
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] FIRST = HDR;
`else
  localparam logic [1:0] FIRST = SEND;
`endif

  logic [1:0]            state;
  logic [BINS-1:0][N-1:0] frame;
  logic [IW-1:0]         k;
  logic                  hs;
  logic                  in_last;
  logic                  last_hs;
  logic                  accept;
  logic                  drop;

  assign out_valid = (state != IDLE);
  assign hs        = out_valid & out_ready;
  assign in_last   = (state == SEND) & (k == KLAST);
  assign last_hs   = hs & in_last;
  assign accept    = in_valid & ((state == IDLE) | last_hs);
  assign drop      = in_valid & ~accept;

  assign out_last    = in_last;
  assign out_bin_idx = k;

`ifdef N_BIN_SER_HEADER_EN
  logic [N-1:0] fcnt;
  logic         in_hdr;

  assign in_hdr   = (state == HDR);
  assign out_hdr  = in_hdr;
  assign out_data = in_hdr    ? fcnt :
                    out_valid ? frame[k] : '0;

  // Frame counter advances once the header word has been taken.
  always_ff @(posedge clk or negedge arest_n) begin
    if (!arest_n) begin
      fcnt <= '0;
    end else if (hs && in_hdr) begin
      fcnt <= fcnt + 1'b1;
    end
  end
`else
  assign out_hdr  = 1'b0;
  assign out_data = out_valid ? frame[k] : '0;
`endif

  // Frame capture, bin stepping and state sequencing.
  always_ff @(posedge clk or negedge arest_n) begin
    if (!arest_n) begin
      state <= IDLE;
      frame <= '0;
      k     <= '0;
    end else if (accept) begin
      frame <= in_data;
      k     <= '0;
      state <= FIRST;
    end else if (hs) begin
      case (state)
`ifdef N_BIN_SER_HEADER_EN
        HDR: state <= SEND;
`endif
        SEND: begin
          if (k == KLAST) begin
            state <= IDLE;
            k     <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of frames dropped while busy.
  always_ff @(posedge clk or negedge arest_n) begin
    if (!arest_n) begin
      overrun_cnt <= '0;
    end else if (drop && overrun_cnt != 16'hFFFF) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_n_bin_serializer.sv
// Scoreboard bench for n_bin_serializer: expected words queued at stimulus,
// checked on each output handshake; define N_BIN_SER_HEADER_EN for header mode.
module tb_n_bin_serializer;

  localparam int N    = 16;
  localparam int BINS = 4;
  localparam int IW   = $clog2(BINS);
  localparam int W    = N + IW + 2;
`ifdef N_BIN_SER_HEADER_EN
  localparam int L = BINS + 1;
`else
  localparam int L = BINS;
`endif

  typedef logic [W-1:0] word_t;
  typedef logic [BINS-1:0][N-1:0] frame_t;

  logic          clk = 0;
  logic          arest_n = 0;
  logic          in_valid = 0;
  frame_t        in_data = '0;
  logic          out_valid;
  logic          out_ready = 1;
  logic [N-1:0]  out_data;
  logic [IW-1:0] out_bin_idx;
  logic          out_last;
  logic          out_hdr;
  logic [15:0]   overrun_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  word_t q[$];
  logic [N-1:0] m_fcnt = '0;

  n_bin_serializer #(.N(N), .BINS(BINS)) dut (
    .clk(clk),
    .arest_n(arest_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_bin_idx(out_bin_idx),
    .out_last(out_last),
    .out_hdr(out_hdr),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input frame_t f);
`ifdef N_BIN_SER_HEADER_EN
    q.push_back({1'b1, 1'b0, {IW{1'b0}}, m_fcnt});
    m_fcnt = m_fcnt + 1'b1;
`endif
    for (int i = 0; i < BINS; i++)
      q.push_back({1'b0, (i == BINS - 1), IW'(i), f[i]});
  endtask

  task automatic send(input frame_t f);
    @(posedge clk); #1;
    in_valid = 1;
    in_data  = f;
    push_frame(f);
    @(posedge clk); #1;
    in_valid = 0;
    chk("latency", {31'd0, out_valid}, 1);
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0) done = 1;
    end
    chk(tag, q.size(), 0);
    repeat (3) @(negedge clk);
    chk({tag, "_idle"}, {31'd0, out_valid}, 0);
  endtask

  // Output monitor: scoreboard compare on handshake, stability while stalled.
  initial begin
    word_t obs, held, exp;
    bit held_v;
    held_v = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!arest_n) begin
        held_v = 0;
      end else begin
        obs = {out_hdr, out_last, out_bin_idx, out_data};
        if (held_v) chk("hold", obs, held);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("spurious", {31'd0, out_valid}, 0);
          end else begin
            exp = q.pop_front();
            chk("word", obs, exp);
          end
        end
        held_v = out_valid && !out_ready;
        held = obs;
      end
    end
  end

  initial begin
    frame_t fa, fb, fc;
    logic pat [4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    fa = {16'd40, 16'd30, 16'd20, 16'd10};
    fb = {16'hBEEF, 16'hCAFE, 16'h1234, 16'h5678};
    fc = {16'h0004, 16'h0003, 16'h0002, 16'h0001};

    #12;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data", {16'd0, out_data}, 0);
    chk("rst_flags", {29'd0, out_last, out_hdr, |out_bin_idx}, 0);
    chk("rst_ovr", {16'd0, overrun_cnt}, 0);
    @(negedge clk);
    arest_n = 1;

    // Basic streaming with ready held high
    send(fa);
    for (int c = 0; c < L; c++) begin
      @(negedge clk);
      chk("t1_cont", {31'd0, out_valid}, 1);
    end
    @(negedge clk);
    chk("t1_end", {31'd0, out_valid}, 0);
    drain("t1_drain");

    // Backpressure pattern 1,0,0,1
    send(fa);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      out_ready = pat[i % 4];
    end
    out_ready = 1;
    drain("t2_drain");

    // Overrun during bin 1
    send(fa);
    @(posedge clk); #1;
    in_valid = 1;
    in_data  = fb;
    @(posedge clk); #1;
    in_valid = 0;
    drain("t3_drain");
    chk("t3_ovr1", {16'd0, overrun_cnt}, 1);

    // Saturation: hold a frame stalled and keep in_valid high
    out_ready = 0;
    send(fc);
    in_valid = 1;
    in_data  = fb;
    repeat (65533) @(posedge clk);
    #1;
    chk("t3_fffe", {16'd0, overrun_cnt}, 32'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_sat", {16'd0, overrun_cnt}, 32'hFFFF);
    in_valid  = 0;
    out_ready = 1;
    drain("t3_sat_drain");
    chk("t3_sat_hold", {16'd0, overrun_cnt}, 32'hFFFF);

    // Back-to-back frame on the last handshake
    send(fa);
    for (int c = 1; c < 2 * L; c++) begin
      @(posedge clk); #1;
      in_valid = (c == L - 1);
      in_data  = fb;
      if (c == L - 1) push_frame(fb);
      chk("t4_cont", {31'd0, out_valid}, 1);
    end
    in_valid = 0;
    drain("t4_drain");

    // Asynchronous reset mid-frame
    send(fc);
    @(posedge clk); #1;
    @(posedge clk); #3;
    arest_n = 0;
    #1;
    chk("t5_valid", {31'd0, out_valid}, 0);
    chk("t5_data", {16'd0, out_data}, 0);
    chk("t5_flags", {29'd0, out_last, out_hdr, |out_bin_idx}, 0);
    chk("t5_ovr", {16'd0, overrun_cnt}, 0);
    q.delete();
    m_fcnt = '0;
    @(negedge clk);
    @(negedge clk);
    arest_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_quiet", {31'd0, out_valid}, 0);
    end
    send(fb);
    drain("t5_drain");

`ifdef N_BIN_SER_HEADER_EN
    // Three frames after reset: headers 0,1,2
    @(negedge clk);
    arest_n = 0;
    q.delete();
    m_fcnt = '0;
    @(negedge clk);
    arest_n = 1;
    send(fa);
    chk("t6_hdr0", {15'd0, out_hdr, out_data}, {15'd0, 1'b1, 16'd0});
    drain("t6_d0");
    send(fb);
    chk("t6_hdr1", {15'd0, out_hdr, out_data}, {15'd0, 1'b1, 16'd1});
    drain("t6_d1");
    send(fc);
    chk("t6_hdr2", {15'd0, out_hdr, out_data}, {15'd0, 1'b1, 16'd2});
    drain("t6_d2");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/n_bin_serializer.md
N_BIN_SERIALIZER -- requirements
Module: n_bin_serializer

Interface
REQ-001 SHALL have parameter N, default 16: bit width of one averaged bin word.
REQ-002 SHALL have parameter BINS, default 4: number of parallel bins per frame; the legal range is 2 to 256.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port arest_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: one-cycle pulse marking a new averaged frame on in_data.
REQ-006 SHALL have port in_data, input, [BINS-1:0][N-1:0]: the averaged bin frame.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data and its sideband signals hold a valid word.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts the current word.
REQ-009 SHALL have port out_data, output, N bits: the serialized word.
REQ-010 SHALL have port out_bin_idx, output, $clog2(BINS) bits: the bin index of the current word.
REQ-011 SHALL have port out_last, output, 1 bit: marks the last word of a frame.
REQ-012 SHALL have port out_hdr, output, 1 bit: marks a header word (see Configuration).
REQ-013 SHALL have port overrun_cnt, output, 16 bits: count of dropped frames.

Function
REQ-014 SHALL implement FSM states IDLE, (HDR), SEND; state HDR exists only when the header is enabled.
REQ-015 IDLE and in_valid=1 SHALL capture all of in_data into an internal frame register and go to HDR (header enabled) or SEND (header disabled).
REQ-016 out_valid SHALL assert in the cycle after capture: latency 1 clk from in_valid to the first word.
REQ-017 SEND SHALL present bin k as out_data=frame[k] with out_bin_idx=k, starting at k=0.
REQ-018 k SHALL advance only on handshake (out_valid and out_ready both 1).
REQ-019 While out_ready=0, out_data, out_bin_idx, out_last and out_hdr SHALL hold stable.
REQ-020 out_last SHALL be 1 only while k=BINS-1 in SEND.
REQ-021 The handshake on the last bin SHALL return the FSM to IDLE and clear out_valid the next cycle, unless REQ-022 applies.
REQ-022 in_valid=1 in the same cycle as the final handshake SHALL be captured, and bin 0 (or the header) of the new frame SHALL follow with no idle cycle.
REQ-023 in_valid=1 in any other non-IDLE cycle SHALL drop the frame, leave the in-progress frame intact, and increment overrun_cnt.
REQ-024 overrun_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-025 The captured frame register SHALL be written only on accepted frames.
REQ-026 out_valid SHALL be 0 in IDLE, except as given by REQ-022.

Reset
REQ-027 arest_n=0 SHALL asynchronously force IDLE, out_valid=0, out_last=0, out_hdr=0, out_bin_idx=0, out_data=0, overrun_cnt=0, frame counter=0, and frame register=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; no remaining words are emitted after release.
REQ-029 The first in_valid on or after the first clk edge with arest_n=1 SHALL be accepted normally.

Configuration
REQ-030 Macro N_BIN_SER_HEADER_EN, when defined, SHALL cause each frame to be preceded by one header word: out_hdr=1, out_bin_idx=0, out_last=0, out_data=frame counter (N bits).
REQ-031 With N_BIN_SER_HEADER_EN defined, the frame counter SHALL increment after the header handshake and wrap modulo 2^N; a frame is then BINS+1 words.
REQ-032 Without N_BIN_SER_HEADER_EN, there SHALL be no HDR state and no frame counter; out_hdr SHALL be tied to 0, and a frame is BINS words.

Verification
REQ-033 Bench SHALL cover: BINS=4, out_ready=1 constant, in_valid with frame {40,30,20,10} (bin3..bin0) -> words 10,20,30,40 on 4 consecutive cycles starting 1 clk after in_valid, out_last on 40, idx 0..3.
REQ-034 Bench SHALL cover: same frame, out_ready toggling 1,0,0,1,... -> each word held stable while out_ready=0, all 4 words delivered in order, none duplicated or lost.
REQ-035 Bench SHALL cover: second in_valid during bin 1 of a frame -> first frame completes unchanged, overrun_cnt=1, second frame never emitted; a further 65536 overruns -> overrun_cnt=16'hFFFF.
REQ-036 Bench SHALL cover: in_valid coincident with the last-bin handshake -> next frame's first word appears on the next cycle, out_valid continuously 1.
REQ-037 Bench SHALL cover: arest_n pulsed low during bin 2 -> all outputs 0 immediately, no further words until a new in_valid, which is then served from bin 0.
REQ-038 Bench SHALL cover, with N_BIN_SER_HEADER_EN defined: three frames -> header words carry 0, 1, 2 with out_hdr=1, each followed by 4 bins.
